// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control block: forwarding mux
// selects and hold-FSM states.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_EXMEM   = 2'd1;
    localparam logic [1:0] FWD_MEMWB   = 2'd2;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding select for one EX operand: EX/MEM match beats MEM/WB match,
// and $0 never forwards.
module fwd_sel_calc
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] r,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_regwrite,
    output logic [1:0]        sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ex_regwrite  && (ex_dst  != '0) && (ex_dst  == r);
    assign mem_hit = mem_regwrite && (mem_dst != '0) && (mem_dst == r);

    always_comb begin
        sel = FWD_REGFILE;
        if (ex_hit)
            sel = FWD_EXMEM;
        else if (mem_hit)
            sel = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_select_ctrl.sv
// 5-stage MIPS pipeline control: registered forwarding selects, load-use
// stall, taken-branch flush and a counter hold for the multi-cycle multiplier.
module hazard_select_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int REG_AW  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_mul,
    input  logic              id_branch_taken,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_regwrite,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              mul_busy
);

    localparam bit         MUL_MULTI = (MUL_LAT > 1);
    localparam logic [3:0] CNT_INIT  = 4'(MUL_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       lu;
    logic [1:0] a_next;
    logic [1:0] b_next;

    assign lu = ex_memread && (ex_dst != '0) &&
                ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_a (
        .r            (id_rs),
        .ex_dst       (ex_dst),
        .ex_regwrite  (ex_regwrite),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .sel          (a_next)
    );

    fwd_sel_calc #(.REG_AW(REG_AW)) u_fwd_b (
        .r            (id_rt),
        .ex_dst       (ex_dst),
        .ex_regwrite  (ex_regwrite),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .sel          (b_next)
    );

    // During the multiply hold the load-use and branch inputs are ignored;
    // they are re-evaluated once back in RUN.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mul_busy     = 1'b0;
        if (state == ST_MUL_BUSY) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mul_busy     = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush = id_branch_taken;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            fwd_a_sel <= FWD_REGFILE;
            fwd_b_sel <= FWD_REGFILE;
        end else begin
            if (idex_write) begin
                fwd_a_sel <= idex_bubble ? FWD_REGFILE : a_next;
                fwd_b_sel <= idex_bubble ? FWD_REGFILE : b_next;
            end
            case (state)
                ST_RUN: begin
                    if (!lu && id_is_mul && MUL_MULTI) begin
                        state <= ST_MUL_BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_MUL_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_select_ctrl.sv
// Self-checking bench for hazard_select_ctrl: table of single-cycle vectors
// with a queue of expected registered selects, plus multi-cycle sequences.
module tb_hazard_select_ctrl;

    localparam int MUL_LAT = 4;
    localparam int REG_AW  = 5;

    logic              Clk = 1'b0;
    logic              Rst;
    logic [REG_AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
    logic              id_uses_rt, id_is_mul, id_branch_taken;
    logic              ex_regwrite, ex_memread, mem_regwrite;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic              pc_write, ifid_write, ifid_flush, idex_write;
    logic              idex_bubble, exmem_bubble, mul_busy;

    always #5 Clk = ~Clk;

    hazard_select_ctrl #(.MUL_LAT(MUL_LAT), .REG_AW(REG_AW)) dut (
        .Clk(Clk), .Rst(Rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_is_mul(id_is_mul), .id_branch_taken(id_branch_taken),
        .ex_dst(ex_dst), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_dst(mem_dst), .mem_regwrite(mem_regwrite),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble),
        .exmem_bubble(exmem_bubble), .mul_busy(mul_busy)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, br;
        logic [4:0] exd;
        logic       exw, exm;
        logic [4:0] memd;
        logic       memw;
        logic       e_pc, e_flush, e_bub;
        logic [1:0] e_a, e_b;
    } vec_t;

    typedef struct {
        logic [1:0] a, b;
    } sel_t;

    vec_t vecs[9];
    sel_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rs, rt, uses_rt, br, exd, exw, exm,
                                memd, memw, e_pc, e_flush, e_bub, e_a, e_b);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = 1'(uses_rt); v.br = 1'(br);
        v.exd = 5'(exd); v.exw = 1'(exw); v.exm = 1'(exm);
        v.memd = 5'(memd); v.memw = 1'(memw);
        v.e_pc = 1'(e_pc); v.e_flush = 1'(e_flush); v.e_bub = 1'(e_bub);
        v.e_a = 2'(e_a); v.e_b = 2'(e_b);
        return v;
    endfunction

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 0; id_is_mul = 0; id_branch_taken = 0;
        ex_dst = '0; ex_regwrite = 0; ex_memread = 0; mem_dst = '0; mem_regwrite = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        idle_inputs();
        //          rs rt ur br exd exw exm memd memw | pc fl bub a  b
        vecs[0] = mk(3, 5, 1, 0, 3, 1, 0, 0, 0,        1, 0, 0,  1, 0);
        vecs[1] = mk(0, 3, 1, 0, 3, 1, 0, 3, 1,        1, 0, 0,  0, 1);
        vecs[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1,        1, 0, 0,  0, 0);
        vecs[3] = mk(7, 7, 1, 0, 2, 1, 0, 7, 1,        1, 0, 0,  2, 2);
        vecs[4] = mk(5, 6, 1, 0, 5, 0, 0, 5, 1,        1, 0, 0,  2, 0);
        vecs[5] = mk(1, 2, 1, 1, 0, 0, 0, 0, 0,        1, 1, 0,  0, 0);
        vecs[6] = mk(1, 9, 0, 0, 9, 1, 1, 0, 0,        1, 0, 0,  0, 1);
        vecs[7] = mk(1, 9, 1, 0, 9, 1, 1, 0, 0,        0, 0, 1,  0, 0);
        vecs[8] = mk(0, 4, 1, 0, 0, 1, 1, 0, 0,        1, 0, 0,  0, 0);

        // reset state
        tick();
        chk("rst_fwd_a", fwd_a_sel, 0);
        chk("rst_fwd_b", fwd_b_sel, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_idex_write", idex_write, 1);
        chk("rst_others", {ifid_flush, idex_bubble, exmem_bubble, mul_busy}, 0);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            sel_t e;
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
            id_branch_taken = vecs[i].br; id_is_mul = 0;
            ex_dst = vecs[i].exd; ex_regwrite = vecs[i].exw; ex_memread = vecs[i].exm;
            mem_dst = vecs[i].memd; mem_regwrite = vecs[i].memw;
            #1;
            chk($sformatf("v%0d_pc_write", i), pc_write, vecs[i].e_pc);
            chk($sformatf("v%0d_ifid_flush", i), ifid_flush, vecs[i].e_flush);
            chk($sformatf("v%0d_idex_bubble", i), idex_bubble, vecs[i].e_bub);
            e.a = vecs[i].e_a; e.b = vecs[i].e_b;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d_fwd_a", i), fwd_a_sel, e.a);
            chk($sformatf("v%0d_fwd_b", i), fwd_b_sel, e.b);
        end

        // load-use: stall one cycle, then forward from MEM/WB
        idle_inputs();
        ex_dst = 3; ex_regwrite = 1; ex_memread = 1; id_rs = 3;
        #1;
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_idex_bubble", idex_bubble, 1);
        tick();
        chk("lu_fwd_a_bubble", fwd_a_sel, 0);
        ex_dst = 0; ex_regwrite = 0; ex_memread = 0; mem_dst = 3; mem_regwrite = 1;
        #1;
        chk("lu_pc_write_resume", pc_write, 1);
        tick();
        chk("lu_fwd_a_memwb", fwd_a_sel, 2);

        // stall beats branch flush, flush on the retry
        idle_inputs();
        ex_dst = 4; ex_regwrite = 1; ex_memread = 1; id_rt = 4; id_uses_rt = 1;
        id_branch_taken = 1;
        #1;
        chk("lubr_flush", ifid_flush, 0);
        chk("lubr_stall", pc_write, 0);
        tick();
        ex_dst = 0; ex_regwrite = 0; ex_memread = 0;
        #1;
        chk("lubr_flush_retry", ifid_flush, 1);
        tick();

        // multiply hold: MUL_LAT-1 busy cycles, selects frozen
        idle_inputs();
        id_rs = 8; ex_dst = 8; ex_regwrite = 1; id_is_mul = 1;
        #1;
        chk("mul_entry_idex_write", idex_write, 1);
        tick();
        idle_inputs();
        id_rs = 6; id_rt = 6; mem_dst = 6; mem_regwrite = 1;
        ex_dst = 6; ex_regwrite = 1; ex_memread = 1; id_branch_taken = 1;
        for (int c = 0; c < MUL_LAT - 1; c++) begin
            chk($sformatf("mul_busy_c%0d", c), mul_busy, 1);
            chk($sformatf("mul_idex_write_c%0d", c), idex_write, 0);
            chk($sformatf("mul_exmem_bubble_c%0d", c), exmem_bubble, 1);
            chk($sformatf("mul_ignore_lu_br_c%0d", c), {pc_write, idex_bubble, ifid_flush}, 0);
            chk($sformatf("mul_fwd_hold_c%0d", c), {fwd_a_sel, fwd_b_sel}, 4'b0100);
            tick();
        end
        idle_inputs();
        #1;
        chk("mul_done_busy", mul_busy, 0);
        chk("mul_done_pc_write", pc_write, 1);
        tick();

        // reset during the hold aborts it
        idle_inputs();
        id_rt = 9; ex_dst = 9; ex_regwrite = 1; id_is_mul = 1;
        tick();
        idle_inputs();
        chk("mulrst_busy1", mul_busy, 1);
        tick();
        chk("mulrst_busy2", mul_busy, 1);
        chk("mulrst_fwd_b_held", fwd_b_sel, 1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("mulrst_busy", mul_busy, 0);
        chk("mulrst_pc_write", pc_write, 1);
        chk("mulrst_fwd", {fwd_a_sel, fwd_b_sel}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_select_ctrl.md
Name: hazard_select_ctrl

Overview:
Pipeline control block for the 5-stage MIPS datapath. It generates the select lines that drive the datapath's 2:1 and 3:1 operand muxes, and the stall, bubble and flush enables for the pipeline registers.
- Registered forwarding selects for the EX-stage ALU operand muxes.
- Load-use stall detection.
- Taken-branch IF/ID flush.
- A counter-based hold FSM for the multi-cycle multiplier.

Parameters:
MUL_LAT, 4, cycles a mult/multu occupies EX (legal 1..16)
REG_AW, 5, register-number width

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  synchronous, active-high reset
id_rs  in  REG_AW  rs field of instruction in ID
id_rt  in  REG_AW  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_is_mul  in  1  ID instruction is mult/multu
id_branch_taken  in  1  branch resolved taken in ID
ex_dst  in  REG_AW  destination register of instruction in EX
ex_regwrite  in  1  EX instruction writes the register file
ex_memread  in  1  EX instruction is a load
mem_dst  in  REG_AW  destination register of instruction in MEM
mem_regwrite  in  1  MEM instruction writes the register file
fwd_a_sel  out  2  EX operand A mux select: 0 regfile, 1 EX/MEM, 2 MEM/WB
fwd_b_sel  out  2  EX operand B mux select, same encoding
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  zero the IF/ID register
idex_write  out  1  ID/EX load enable
idex_bubble  out  1  load a NOP into ID/EX
exmem_bubble  out  1  load a NOP into EX/MEM
mul_busy  out  1  FSM in MUL_BUSY

Behaviour:
Reset (values at the clock edge after Rst=1):
- State RUN, cnt=0, fwd_a_sel=fwd_b_sel=0.
- Combinational outputs then evaluate to pc_write=ifid_write=idex_write=1, all others 0.
- Rst asserted mid-MUL_BUSY aborts the hold; the multiplier result is discarded by the datapath reset.

Load-use hazard (lu):
- lu = ex_memread & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).

Forwarding selects (registered):
- Computed from ID operands against EX/MEM destinations; loaded at the edge when idex_write=1.
- Per operand r (rs for A, rt for B):
  - sel=1 if ex_regwrite & ex_dst!=0 & ex_dst==r;
  - else sel=2 if mem_regwrite & mem_dst!=0 & mem_dst==r;
  - else 0.
- The EX match has priority over the MEM match.
- When idex_bubble=1, the selects load 0.
- When idex_write=0, the selects hold.
- Register $0 never forwards.
- WB-to-ID hazards are covered by the register file writing in the first half-cycle; this block does not handle them.

FSM states: RUN, MUL_BUSY.
- RUN:
  - lu=1: pc_write=0, ifid_write=0, idex_bubble=1 (exactly a 1-cycle stall; the load then forwards from MEM/WB as sel=2).
  - lu=0 & id_branch_taken: ifid_flush=1.
  - lu=1 & id_branch_taken: stall wins, flush suppressed; the branch is re-evaluated next cycle.
  - lu=0 & id_is_mul & MUL_LAT>1: the mult advances into EX; next state MUL_BUSY with cnt=MUL_LAT-1.
- MUL_BUSY:
  - pc_write=ifid_write=idex_write=0, exmem_bubble=1, mul_busy=1.
  - cnt decrements each cycle; when cnt==1, next state RUN.
  - The mult therefore occupies EX exactly MUL_LAT cycles.
  - ifid_flush is forced 0 and lu is ignored; both are re-evaluated in RUN.
- MUL_LAT=1: MUL_BUSY is never entered.

Width rules:
- cnt is 4 bits.
- All comparisons are REG_AW-bit equality.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FWD_REGFILE=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - State encodings ST_RUN, ST_MUL_BUSY.
- One sub-module, fwd_sel_calc: combinational priority compare for one operand, instantiated twice (A and B). Its outputs are registered in hazard_select_ctrl.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 (ex_dst=3 when id_rs=3) -> next edge fwd_a_sel=1, no stall.
- ex_dst=3 & mem_dst=3 both writing, id_rt=3, id_uses_rt=1 -> fwd_b_sel=1 (EX priority); ex_dst=0 with id_rs=0 -> fwd_a_sel=0.
- lw $3 in EX (ex_memread=1), id_rs=3 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next edge fwd_a_sel=0; following cycle (lw in MEM) sel=2, pc_write=1.
- lu=1 and id_branch_taken=1 same cycle -> ifid_flush=0, stall asserted; next cycle (lu=0, branch still taken) -> ifid_flush=1.
- MUL_LAT=4, id_is_mul=1 in RUN -> mul_busy=1 for exactly 3 cycles with idex_write=0 and exmem_bubble=1, then RUN; fwd selects unchanged during the hold.
- Rst=1 on the 2nd MUL_BUSY cycle -> after that edge mul_busy=0, pc_write=1, fwd_a_sel=fwd_b_sel=0.
